event_window_sched: RTL and testbench

//  Sequencer in front of EventFIFO3_hash. Accepts a stream of (addr, value) events and writes

---
 rtl/event_window_sched.sv | 172 +++++++++++++++++
 tb/tb_event_window_sched.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_window_sched.sv
// Sequencer in front of the 3-row event FIFO: writes each event, then reads one 3x3 window
// centred on it once the row below is present (or on flush / full queue) and forwards it.
module event_window_sched #(
  parameter int DATA_WIDTH = 4,
  parameter int PEND_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        s_event_value,
  input  logic [15:0]                  s_event_addr,
  input  logic                         s_event_valid,
  output logic                         s_event_ready,
  input  logic                         s_flush,
  output logic [DATA_WIDTH-1:0]        fifo_in_event_value,
  output logic [15:0]                  fifo_in_event_addr,
  output logic                         fifo_in_event_valid,
  input  logic                         fifo_write_done,
  output logic [15:0]                  fifo_out_window_addr,
  output logic                         fifo_read_req,
  input  logic [9*DATA_WIDTH-1:0]      fifo_window_value,
  input  logic                         fifo_window_valid,
  output logic [9*DATA_WIDTH-1:0]      m_window_value,
  output logic [15:0]                  m_window_addr,
  output logic                         m_window_valid,
  input  logic                         m_window_ready,
  output logic [$clog2(PEND_DEPTH):0]  pend_count,
  output logic                         busy
);
  localparam int PW = $clog2(PEND_DEPTH);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR      = 3'd1;
  localparam logic [2:0] WR_WAIT = 3'd2;
  localparam logic [2:0] RD_REQ  = 3'd3;
  localparam logic [2:0] RD_WAIT = 3'd4;
  localparam logic [2:0] OUT     = 3'd5;

  // a is ahead of b when the modulo-256 row distance is 1..127
  function automatic logic row_ahead(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] d;
    d = a - b;
    return (d != 8'd0) && !d[7];
  endfunction

  function automatic logic drain_needed(input logic empty, input logic [7:0] row,
                                        input logic [7:0] head_row);
    logic [7:0] d;
    d = row - head_row;
    return !empty && (d >= 8'd2) && !d[7];
  endfunction

  logic [2:0]              state_q, state_d;
  logic                    lat_vld_q, lat_vld_d;
  logic [15:0]             lat_addr_q, lat_addr_d;
  logic [DATA_WIDTH-1:0]   lat_val_q, lat_val_d;
  logic [PW:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]              last_row_q, last_row_d;
  logic                    flush_q, flush_d;
  logic                    rst_done_q;
  logic [9*DATA_WIDTH-1:0] win_value_q, win_value_d;
  logic [15:0]             win_addr_q, win_addr_d;
  logic [15:0]             q_mem [PEND_DEPTH];

  logic        q_empty, q_full, head_ready, push, pop, accept;
  logic [15:0] head_addr;

  assign q_empty    = (wr_ptr_q == rd_ptr_q);
  assign q_full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head_addr  = q_mem[rd_ptr_q[PW-1:0]];
  assign head_ready = flush_q || row_ahead(last_row_q, head_addr[15:8]) || q_full;

  // Ready is withheld while a pending read would win the IDLE arbitration, so no event is lost
  assign s_event_ready = rst_done_q && !rst && (state_q == IDLE) && !lat_vld_q && !q_full &&
                         !(!q_empty && head_ready);
  assign accept        = s_event_valid && s_event_ready;

  always_comb begin
    state_d     = state_q;
    lat_vld_d   = lat_vld_q;
    lat_addr_d  = lat_addr_q;
    lat_val_d   = lat_val_q;
    last_row_d  = last_row_q;
    win_value_d = win_value_q;
    win_addr_d  = win_addr_q;
    push        = 1'b0;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!q_empty && head_ready) begin
          state_d = RD_REQ;
        end else if (accept) begin
          lat_vld_d  = 1'b1;
          lat_addr_d = s_event_addr;
          lat_val_d  = s_event_value;
          state_d    = drain_needed(q_empty, s_event_addr[15:8], head_addr[15:8]) ? RD_REQ : WR;
        end
      end
      WR:      state_d = WR_WAIT;
      WR_WAIT: begin
        if (fifo_write_done) begin
          push       = 1'b1;
          last_row_d = lat_addr_q[15:8];
          lat_vld_d  = 1'b0;
          state_d    = IDLE;
        end
      end
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: begin
        if (fifo_window_valid) begin
          win_value_d = fifo_window_value;
          win_addr_d  = head_addr;
          pop         = 1'b1;
          state_d     = OUT;
        end
      end
      OUT: begin
        if (m_window_ready) begin
          if (lat_vld_q)
            state_d = drain_needed(q_empty, lat_addr_q[15:8], head_addr[15:8]) ? RD_REQ : WR;
          else
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign flush_d  = s_flush || (flush_q && !(q_empty && (state_q == IDLE)));
  assign wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lat_vld_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      last_row_q <= 8'd0;
      flush_q    <= 1'b0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_vld_q  <= lat_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      last_row_q <= last_row_d;
      flush_q    <= flush_d;
      rst_done_q <= 1'b1;
    end
  end

  // Datapath registers carry no reset; outputs are gated by state instead
  always_ff @(posedge clk) begin
    lat_addr_q  <= lat_addr_d;
    lat_val_q   <= lat_val_d;
    win_value_q <= win_value_d;
    win_addr_q  <= win_addr_d;
    if (push) q_mem[wr_ptr_q[PW-1:0]] <= lat_addr_q;
  end

  assign fifo_in_event_valid  = (state_q == WR);
  assign fifo_in_event_addr   = fifo_in_event_valid ? lat_addr_q : 16'd0;
  assign fifo_in_event_value  = fifo_in_event_valid ? lat_val_q : '0;
  assign fifo_read_req        = (state_q == RD_REQ);
  assign fifo_out_window_addr = fifo_read_req ? head_addr : 16'd0;
  assign m_window_valid       = (state_q == OUT);
  assign m_window_value       = m_window_valid ? win_value_q : '0;
  assign m_window_addr        = m_window_valid ? win_addr_q : 16'd0;
  assign pend_count           = wr_ptr_q - rd_ptr_q;
  assign busy                 = (state_q != IDLE) || !q_empty || flush_q;

endmodule

// File: tb/tb_event_window_sched.sv
// Bench for event_window_sched with a behavioural 3-row FIFO stand-in and a window model
// computed from the arrival-ordered event list.
module tb_event_window_sched;
  localparam int DW = 4;
  localparam int WW = 9 * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_event_value;
  logic [15:0]   s_event_addr;
  logic          s_event_valid, s_event_ready, s_flush;
  logic [DW-1:0] fifo_in_event_value;
  logic [15:0]   fifo_in_event_addr, fifo_out_window_addr, m_window_addr;
  logic          fifo_in_event_valid, fifo_write_done, fifo_read_req, fifo_window_valid;
  logic [WW-1:0] fifo_window_value, m_window_value;
  logic          m_window_valid, m_window_ready, busy;
  logic [3:0]    pend_count;

  always #5 clk = ~clk;

  event_window_sched #(.DATA_WIDTH(DW), .PEND_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .s_event_value(s_event_value), .s_event_addr(s_event_addr),
    .s_event_valid(s_event_valid), .s_event_ready(s_event_ready), .s_flush(s_flush),
    .fifo_in_event_value(fifo_in_event_value), .fifo_in_event_addr(fifo_in_event_addr),
    .fifo_in_event_valid(fifo_in_event_valid), .fifo_write_done(fifo_write_done),
    .fifo_out_window_addr(fifo_out_window_addr), .fifo_read_req(fifo_read_req),
    .fifo_window_value(fifo_window_value), .fifo_window_valid(fifo_window_valid),
    .m_window_value(m_window_value), .m_window_addr(m_window_addr),
    .m_window_valid(m_window_valid), .m_window_ready(m_window_ready),
    .pend_count(pend_count), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0]   st_addr[$];
  logic [DW-1:0] st_val[$];
  logic [16:0]   op_log[$];
  int            wd_cnt;
  int            wd_delay = 0;
  int            proto_err = 0;
  logic [15:0]   got_addr[$];
  logic [WW-1:0] got_val[$];
  logic [15:0]   ev_addr[$];
  logic [DW-1:0] ev_val[$];
  logic          rdy_force = 1'b1;
  logic          rdy_val = 1'b0;

  logic [15+16+16+16+WW+DW+1+1+1+1+1+4:0] outs_all;
  assign outs_all = {s_event_ready, fifo_in_event_valid, fifo_read_req, m_window_valid, busy,
                     pend_count, fifo_in_event_addr, fifo_out_window_addr, m_window_addr,
                     m_window_value, fifo_in_event_value, 16'd0};

  // FIFO stand-in: keeps rows within two of the newest written row
  function automatic logic [WW-1:0] fifo_win(input logic [15:0] ca);
    logic [WW-1:0] w;
    logic [15:0]   a;
    logic [7:0]    last, d;
    w = '0;
    last = (st_addr.size() > 0) ? st_addr[st_addr.size()-1][15:8] : 8'd0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        a = {ca[15:8] + 8'(i) - 8'd1, ca[7:0] + 8'(j) - 8'd1};
        for (int e = 0; e < st_addr.size(); e++) begin
          d = last - st_addr[e][15:8];
          if (st_addr[e] == a && d <= 8'd2) w[(8-(i*3+j))*DW +: DW] = st_val[e];
        end
      end
    return w;
  endfunction

  always @(posedge clk) begin
    fifo_write_done   <= 1'b0;
    fifo_window_valid <= 1'b0;
    if (rst) begin
      st_addr.delete();
      st_val.delete();
      op_log.delete();
      wd_cnt <= 0;
    end else begin
      if (fifo_read_req) begin
        if (fifo_in_event_valid || wd_cnt != 0) proto_err <= proto_err + 1;
        op_log.push_back({1'b1, fifo_out_window_addr});
        fifo_window_valid <= 1'b1;
        fifo_window_value <= fifo_win(fifo_out_window_addr);
      end
      if (fifo_in_event_valid) begin
        st_addr.push_back(fifo_in_event_addr);
        st_val.push_back(fifo_in_event_value);
        op_log.push_back({1'b0, fifo_in_event_addr});
        wd_cnt <= (wd_delay == 0) ? int'($urandom_range(1, 4)) : wd_delay;
      end else if (wd_cnt == 1) begin
        fifo_write_done <= 1'b1;
        wd_cnt <= 0;
      end else if (wd_cnt > 1) begin
        wd_cnt <= wd_cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      got_addr.delete();
      got_val.delete();
    end else if (m_window_valid && m_window_ready) begin
      got_addr.push_back(m_window_addr);
      got_val.push_back(m_window_value);
    end
  end

  initial begin
    m_window_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      m_window_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
    end
  end

  // Reference window: event k sees every earlier event plus every later one up to the
  // first event one row ahead (inclusive) or two+ rows ahead (exclusive); else all of them.
  function automatic logic [WW-1:0] exp_win(input int k);
    logic [WW-1:0] w;
    logic [15:0]   a;
    logic [7:0]    d;
    int            cut;
    w = '0;
    cut = ev_addr.size();
    for (int j = k + 1; j < ev_addr.size(); j++) begin
      d = ev_addr[j][15:8] - ev_addr[k][15:8];
      if (d != 8'd0 && !d[7]) begin
        cut = (d == 8'd1) ? j + 1 : j;
        break;
      end
    end
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        a = {ev_addr[k][15:8] + 8'(i) - 8'd1, ev_addr[k][7:0] + 8'(j) - 8'd1};
        for (int e = 0; e < cut; e++)
          if (ev_addr[e] == a) w[(8-(i*3+j))*DW +: DW] = ev_val[e];
      end
    return w;
  endfunction

  task automatic do_reset();
    rst = 1'b1; s_event_valid = 1'b0; s_flush = 1'b0; wd_delay = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    ev_addr.delete();
    ev_val.delete();
  endtask

  task automatic send_ev(input logic [15:0] a, input logic [DW-1:0] v);
    int n;
    n = 0;
    s_event_addr = a; s_event_value = v; s_event_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!s_event_ready && n < 2000);
    if (n >= 2000) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: event %h not accepted, required acceptance within 2000 cycles", a);
    end
    @(posedge clk); #1;
    s_event_valid = 1'b0;
    ev_addr.push_back(a);
    ev_val.push_back(v);
  endtask

  task automatic pulse_flush();
    s_flush = 1'b1;
    @(posedge clk); #1;
    s_flush = 1'b0;
  endtask

  task automatic wait_windows(input int n, input bit need_idle, output bit ok);
    int c;
    c = 0;
    while ((got_addr.size() < n || (need_idle && busy)) && c < 3000) begin
      @(posedge clk); #1;
      c++;
    end
    ok = (c < 3000);
  endtask

  task automatic test_reset();
    rst = 1'b1; s_event_valid = 1'b0; s_flush = 1'b0; s_event_addr = '0; s_event_value = '0;
    rdy_force = 1'b1; rdy_val = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_tests++;
    if (outs_all !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h required 0", outs_all);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (s_event_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b required 1", s_event_ready);
    end
  endtask

  task automatic test_flush_single();
    bit ok;
    do_reset(); rdy_force = 1'b0;
    send_ev(16'h0505, 4'd7);
    pulse_flush();
    wait_windows(1, 1'b1, ok);
    n_tests++;
    if (!ok || got_addr.size() != 1 || got_addr[0] !== 16'h0505 || got_val[0] !== 36'h000070000) begin
      n_fail++; $display("FAIL flush_single: ok=%0b n=%0d addr=%h val=%h required 0505/000070000",
                         ok, got_addr.size(), got_addr[0], got_val[0]);
    end
    n_tests++;
    if (pend_count !== 4'd0) begin
      n_fail++; $display("FAIL flush_pend: got %0d required 0", pend_count);
    end
  endtask

  task automatic test_row_below();
    bit ok;
    do_reset(); rdy_force = 1'b0;
    send_ev(16'h0504, 4'd1);
    send_ev(16'h0505, 4'd2);
    send_ev(16'h0605, 4'd3);
    wait_windows(2, 1'b0, ok);
    n_tests++;
    if (!ok || op_log.size() != 5 || op_log[2] !== {1'b0, 16'h0605} ||
        op_log[3] !== {1'b1, 16'h0504} || op_log[4] !== {1'b1, 16'h0505}) begin
      n_fail++; $display("FAIL row_below_order: ok=%0b ops=%0d op3=%h op4=%h required W0605,R0504,R0505",
                         ok, op_log.size(), op_log[3], op_log[4]);
    end
    n_tests++;
    if (got_addr.size() != 2 || got_val[0] !== 36'h000012003 || got_val[1] !== 36'h000120030) begin
      n_fail++; $display("FAIL row_below_values: got %h %h required 000012003 000120030",
                         got_val[0], got_val[1]);
    end
    n_tests++;
    if (pend_count !== 4'd1) begin
      n_fail++; $display("FAIL row_below_pend: got %0d required 1", pend_count);
    end
  endtask

  task automatic test_far_row();
    bit ok;
    do_reset(); rdy_force = 1'b0;
    send_ev(16'h0505, 4'd5);
    send_ev(16'h0905, 4'd6);
    pulse_flush();
    wait_windows(2, 1'b1, ok);
    n_tests++;
    if (!ok || op_log.size() != 4 || op_log[1] !== {1'b1, 16'h0505} || op_log[2] !== {1'b0, 16'h0905}) begin
      n_fail++; $display("FAIL far_row_order: ok=%0b op1=%h op2=%h required R0505 then W0905",
                         ok, op_log[1], op_log[2]);
    end
    n_tests++;
    if (got_addr.size() != 2 || got_val[0] !== 36'h000050000) begin
      n_fail++; $display("FAIL far_row_value: got %h required 000050000", got_val[0]);
    end
  endtask

  task automatic test_full_queue();
    bit ok, stable;
    int c;
    do_reset(); rdy_force = 1'b1; rdy_val = 1'b0;
    for (int i = 0; i < 8; i++) send_ev({8'h03, 8'h10 + 8'(i)}, 4'(i + 1));
    c = 0;
    while (!m_window_valid && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    n_tests++;
    if (c >= 200 || s_event_ready !== 1'b0 || pend_count !== 4'd7) begin
      n_fail++; $display("FAIL full_force_read: wait=%0d ready=%b pend=%0d required valid, ready 0, pend 7",
                         c, s_event_ready, pend_count);
    end
    n_tests++;
    if (m_window_addr !== 16'h0310 || m_window_value !== 36'h000012000) begin
      n_fail++; $display("FAIL full_window: got %h/%h required 0310/000012000", m_window_addr, m_window_value);
    end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!m_window_valid || m_window_value !== 36'h000012000 || s_event_ready) stable = 1'b0;
    end
    n_tests++;
    if (!stable) begin
      n_fail++; $display("FAIL full_hold: got unstable/ready during stall, required held window and ready 0");
    end
    rdy_val = 1'b1;
    @(posedge clk); #1;
    rdy_val = 1'b0;
    n_tests++;
    if (m_window_valid !== 1'b0 || s_event_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_release: valid=%b ready=%b required 0/1", m_window_valid, s_event_ready);
    end
    rdy_force = 1'b0;
    pulse_flush();
    wait_windows(8, 1'b1, ok);
    n_tests++;
    if (!ok || got_addr.size() != 8 || got_addr[7] !== 16'h0317) begin
      n_fail++; $display("FAIL full_drain: n=%0d last=%h required 8 windows ending 0317",
                         got_addr.size(), got_addr[7]);
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset(); rdy_force = 1'b0; wd_delay = 20;
    send_ev(16'h0505, 4'd7);
    repeat (2) @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b1 || s_event_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_write_busy: busy=%b ready=%b required 1/0", busy, s_event_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++;
    if (outs_all !== '0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got %h required 0", outs_all);
    end
    @(posedge clk); #1;
    n_tests++;
    if (s_event_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_ready: got %b required 1", s_event_ready);
    end
    wd_delay = 0;
  endtask

  task automatic test_row_wrap();
    bit ok;
    do_reset(); rdy_force = 1'b0;
    send_ev(16'hFF10, 4'd6);
    send_ev(16'h0010, 4'd9);
    wait_windows(1, 1'b0, ok);
    n_tests++;
    if (!ok || op_log.size() < 3 || op_log[1] !== {1'b0, 16'h0010} || op_log[2] !== {1'b1, 16'hFF10}) begin
      n_fail++; $display("FAIL wrap_order: ok=%0b op1=%h op2=%h required W0010 then RFF10",
                         ok, op_log[1], op_log[2]);
    end
    n_tests++;
    if (got_addr.size() < 1 || got_addr[0] !== 16'hFF10 || got_val[0] !== 36'h000060090) begin
      n_fail++; $display("FAIL wrap_value: got %h/%h required FF10/000060090", got_addr[0], got_val[0]);
    end
  endtask

  task automatic test_random();
    bit ok;
    logic [7:0] r;
    int nev, bad;
    for (int it = 0; it < 3; it++) begin
      do_reset(); rdy_force = 1'b0;
      r = 8'($urandom_range(0, 255));
      while (ev_addr.size() < 24) begin
        nev = $urandom_range(1, 4);
        for (int e = 0; e < nev; e++)
          send_ev({r, 8'($urandom_range(8'h20, 8'h26))}, 4'($urandom_range(1, 15)));
        r = r + 8'(($urandom_range(0, 3) == 0) ? $urandom_range(2, 3) : 1);
      end
      pulse_flush();
      wait_windows(ev_addr.size(), 1'b1, ok);
      n_tests++;
      if (!ok || got_addr.size() != ev_addr.size() || pend_count !== 4'd0) begin
        n_fail++; $display("FAIL random_count: ok=%0b got %0d windows pend=%0d required %0d windows pend 0",
                           ok, got_addr.size(), pend_count, ev_addr.size());
      end
      bad = 0;
      for (int k = 0; k < ev_addr.size() && k < got_addr.size(); k++) begin
        n_tests++;
        if (got_addr[k] !== ev_addr[k] || got_val[k] !== exp_win(k)) begin
          n_fail++;
          if (bad < 4) $display("FAIL random_window[%0d]: got %h/%h required %h/%h",
                                k, got_addr[k], got_val[k], ev_addr[k], exp_win(k));
          bad++;
        end
      end
      n_tests++;
      if (proto_err != 0) begin
        n_fail++; $display("FAIL read_during_write: got %0d overlaps required 0", proto_err);
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_flush_single();
    test_row_below();
    test_far_row();
    test_full_queue();
    test_reset_mid_write();
    test_row_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
